// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for an SRAM-like req/addr_ok/data_ok data bus.
// Checks alignment, builds strobes and store data, stalls until done, and extends load data.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              flush,
  input  logic              pipe_ready,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              addr_err_load,
  output logic              addr_err_store,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t state, state_n;
  logic   cancel_q, cancel_n;
  logic   signed_q;
  logic   capture;

  logic              is_load, is_store, ld_signed, misaligned;
  logic [1:0]        size_n;
  logic              idle_valid, accept;
  logic [3:0]        wstrb_n;
  logic [DATA_W-1:0] wdata_n;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] rdata_n;

  // Opcode decode and alignment check for the instruction currently in MEM
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    ld_signed = 1'b0;
    size_n    = 2'd0;
    case (opcode)
      OP_LB:   begin is_load  = 1'b1; ld_signed = 1'b1; size_n = 2'd0; end
      OP_LH:   begin is_load  = 1'b1; ld_signed = 1'b1; size_n = 2'd1; end
      OP_LW:   begin is_load  = 1'b1; size_n = 2'd2; end
      OP_LBU:  begin is_load  = 1'b1; size_n = 2'd0; end
      OP_LHU:  begin is_load  = 1'b1; size_n = 2'd1; end
      OP_SB:   begin is_store = 1'b1; size_n = 2'd0; end
      OP_SH:   begin is_store = 1'b1; size_n = 2'd1; end
      OP_SW:   begin is_store = 1'b1; size_n = 2'd2; end
      default: ;
    endcase
    misaligned = ((size_n == 2'd2) && (addr[1:0] != 2'b00)) ||
                 ((size_n == 2'd1) && addr[0]);
  end

  assign idle_valid     = (state == ST_IDLE) && mem_en && !flush && !rst && (is_load || is_store);
  assign accept         = idle_valid && !misaligned;
  assign addr_err_load  = idle_valid && misaligned && is_load;
  assign addr_err_store = idle_valid && misaligned && is_store;
  assign badvaddr       = (addr_err_load || addr_err_store) ? addr : '0;

  // Byte enables and lane-replicated store data
  always_comb begin
    wstrb_n = 4'b0000;
    wdata_n = wdata_in;
    case (size_n)
      2'd0: begin
        wstrb_n = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata_in[7:0]}};
      end
      2'd1: begin
        wstrb_n = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{wdata_in[15:0]}};
      end
      default: begin
        wstrb_n = 4'b1111;
        wdata_n = wdata_in;
      end
    endcase
    if (!is_store) wstrb_n = 4'b0000;
  end

  // Load extraction uses the offset latched at issue (low bits of data_addr)
  always_comb begin
    byte_sel = data_rdata[7:0];
    case (data_addr[1:0])
      2'd0:    byte_sel = data_rdata[7:0];
      2'd1:    byte_sel = data_rdata[15:8];
      2'd2:    byte_sel = data_rdata[23:16];
      default: byte_sel = data_rdata[31:24];
    endcase
    half_sel = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (data_size)
      2'd0:    rdata_n = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      2'd1:    rdata_n = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: rdata_n = data_rdata;
    endcase
  end

  // Next state, cancel tracking and control outputs
  always_comb begin
    state_n  = state;
    cancel_n = cancel_q;
    stall    = 1'b0;
    done     = 1'b0;
    capture  = 1'b0;
    data_req = 1'b0;
    case (state)
      ST_IDLE: begin
        cancel_n = 1'b0;
        stall    = accept;
        if (accept) state_n = ST_REQ;
      end
      ST_REQ: begin
        data_req = 1'b1;
        stall    = cancel_q ? mem_en : 1'b1;
        if (flush) cancel_n = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            if (cancel_q || flush) begin
              state_n  = ST_IDLE;
              cancel_n = 1'b0;
            end else begin
              state_n = ST_DONE;
              capture = 1'b1;
            end
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = cancel_q ? mem_en : 1'b1;
        if (flush) cancel_n = 1'b1;
        if (data_data_ok) begin
          if (cancel_q || flush) begin
            state_n  = ST_IDLE;
            cancel_n = 1'b0;
          end else begin
            state_n = ST_DONE;
            capture = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (flush || pipe_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) begin
      stall = 1'b0;
      done  = 1'b0;
    end
  end

  // State, cancel flag, latched bus fields and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cancel_q   <= 1'b0;
      signed_q   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wstrb <= 4'b0000;
      data_wdata <= '0;
      rdata      <= '0;
    end else begin
      state    <= state_n;
      cancel_q <= cancel_n;
      if (accept) begin
        signed_q   <= ld_signed;
        data_wr    <= is_store;
        data_size  <= size_n;
        data_addr  <= addr;
        data_wstrb <= wstrb_n;
        data_wdata <= wdata_n;
      end
      if (capture) rdata <= rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl; the bench drives the bus responder
// itself and compares against a transaction-level byte-lane model.
module tb_mem_access_ctrl;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic        clk = 1'b0;
  logic        rst, mem_en, flush, pipe_ready;
  logic [5:0]  opcode;
  logic [31:0] addr, wdata_in;
  logic        stall, done, addr_err_load, addr_err_store;
  logic [31:0] rdata, badvaddr;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .opcode(opcode), .addr(addr),
    .wdata_in(wdata_in), .flush(flush), .pipe_ready(pipe_ready), .stall(stall),
    .rdata(rdata), .done(done), .addr_err_load(addr_err_load),
    .addr_err_store(addr_err_store), .badvaddr(badvaddr), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Access width in bytes; 0 for anything that is not a load/store
  function automatic int op_bytes(input logic [5:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [31:0] exp_size(input logic [5:0] op);
    int n = op_bytes(op);
    return (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2;
  endfunction

  function automatic logic [31:0] exp_strb(input logic [5:0] op, input logic [31:0] a);
    int n = op_bytes(op);
    int off = int'(a[1:0]);
    if (!op_store(op)) return 32'd0;
    return 32'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] rt);
    int n = op_bytes(op);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 4; i++) w = w | (((rt >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] word);
    int n = op_bytes(op);
    longint mask = (longint'(1) << (8 * n)) - 1;
    longint v = (longint'(word) >> (8 * int'(a[1:0]))) & mask;
    if (op == LB && v >= 128) v = v + 64'hFFFF_FFFF - 64'hFF;
    if (op == LH && v >= 32768) v = v + 64'hFFFF_FFFF - 64'hFFFF;
    return 32'(v);
  endfunction

  task automatic chk_bus(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] rt);
    chk({tag, "_req"}, 32'(data_req), 32'd1);
    chk({tag, "_wr"}, 32'(data_wr), 32'(op_store(op)));
    chk({tag, "_size"}, 32'(data_size), exp_size(op));
    chk({tag, "_addr"}, data_addr, a);
    chk({tag, "_wstrb"}, 32'(data_wstrb), exp_strb(op, a));
    if (op_store(op)) chk({tag, "_wdata"}, data_wdata, exp_wdata(op, rt));
    chk({tag, "_stall"}, 32'(stall), 32'd1);
  endtask

  // Full transaction starting from IDLE: issue, aok_d req-only cycles, addr_ok cycle,
  // dok_d cycles until data_ok (0 = same cycle), then pr_d cycles of pipe_ready=0 in DONE.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] word, input int aok_d, input int dok_d,
                         input int pr_d);
    logic [31:0] exp_rd = exp_load(op, a, word);
    mem_en = 1'b1; opcode = op; addr = a; wdata_in = rt; flush = 1'b0;
    pipe_ready = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("issue_stall", 32'(stall), 32'd1);
    chk("issue_errl", 32'(addr_err_load), 32'd0);
    chk("issue_errs", 32'(addr_err_store), 32'd0);
    chk("issue_done", 32'(done), 32'd0);
    tick();
    for (int i = 0; i < aok_d; i++) begin
      chk_bus("req_hold", op, a, rt);
      tick();
    end
    chk_bus("req_aok", op, a, rt);
    data_addr_ok = 1'b1;
    if (dok_d == 0) begin data_data_ok = 1'b1; data_rdata = word; end
    #1;
    chk("aok_stall", 32'(stall), 32'd1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    if (dok_d > 0) begin
      for (int i = 0; i < dok_d - 1; i++) begin
        chk("wait_req", 32'(data_req), 32'd0);
        chk("wait_stall", 32'(stall), 32'd1);
        tick();
      end
      data_data_ok = 1'b1; data_rdata = word;
      #1;
      chk("dok_stall", 32'(stall), 32'd1);
      chk("dok_done", 32'(done), 32'd0);
      tick();
      data_data_ok = 1'b0;
    end
    for (int i = 0; i <= pr_d; i++) begin
      data_rdata = $urandom;
      pipe_ready = (i == pr_d);
      #1;
      chk("done_flag", 32'(done), 32'd1);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_req", 32'(data_req), 32'd0);
      if (!op_store(op)) chk("done_rdata", rdata, exp_rd);
      tick();
    end
    mem_en = 1'b0; pipe_ready = 1'b0;
    #1;
    chk("after_done", 32'(done), 32'd0);
  endtask

  // Misaligned or non-memory instruction in IDLE: nothing may reach the bus
  task automatic run_noissue(input logic [5:0] op, input logic [31:0] a, input bit misal);
    mem_en = 1'b1; opcode = op; addr = a; wdata_in = $urandom; flush = 1'b0;
    #1;
    chk("ni_stall", 32'(stall), 32'd0);
    chk("ni_errl", 32'(addr_err_load), 32'(misal && !op_store(op)));
    chk("ni_errs", 32'(addr_err_store), 32'(misal && op_store(op)));
    if (misal) chk("ni_badvaddr", badvaddr, a);
    tick();
    chk("ni_req", 32'(data_req), 32'd0);
    mem_en = 1'b0;
  endtask

  logic [5:0] mem_ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
  logic [5:0] other_ops [5] = '{6'h00, 6'h08, 6'h22, 6'h2E, 6'h30};

  initial begin
    rst = 1'b1; mem_en = 1'b0; opcode = 6'd0; addr = 32'd0; wdata_in = 32'd0;
    flush = 1'b0; pipe_ready = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_badv", badvaddr, 32'd0);

    // Directed cases
    run_txn(LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1, 0);
    chk("lb_value", rdata, 32'hFFFF_FF80);
    run_txn(SH, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 1, 0);
    chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
    chk("sh_wstrb", 32'(data_wstrb), 32'hC);
    run_noissue(LW, 32'h0000_3001, 1'b1);
    run_noissue(SW, 32'h0000_3002, 1'b1);
    run_noissue(LH, 32'h0000_3003, 1'b1);
    run_txn(LHU, 32'h0000_4002, 32'h0, 32'h8001_0000, 2, 1, 2);
    chk("lhu_value", rdata, 32'h0000_8001);
    run_txn(LW, 32'h0000_4100, 32'h0, 32'h1234_5678, 0, 0, 0);
    run_txn(SB, 32'h0000_4101, 32'h0000_005A, 32'h0, 1, 2, 1);

    // Flush in IDLE: nothing issued
    mem_en = 1'b1; opcode = LW; addr = 32'h0000_4200; flush = 1'b1;
    #1;
    chk("fidle_stall", 32'(stall), 32'd0);
    chk("fidle_err", 32'(addr_err_load), 32'd0);
    tick();
    chk("fidle_req", 32'(data_req), 32'd0);
    flush = 1'b0; mem_en = 1'b0;

    // Flush in WAIT, new LBU waits for the drain then issues normally
    mem_en = 1'b1; opcode = LW; addr = 32'h0000_5000;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1; opcode = LBU; addr = 32'h0000_5001;
    #1;
    chk("fw_stall0", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("fw_stall1", 32'(stall), 32'd1);
    chk("fw_done1", 32'(done), 32'd0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fw_stall2", 32'(stall), 32'd1);
    tick();
    data_data_ok = 1'b0;
    run_txn(LBU, 32'h0000_5001, 32'h0, 32'h0000_F200, 0, 1, 0);
    chk("lbu_value", rdata, 32'h0000_00F2);

    // Flush in DONE drops the result
    mem_en = 1'b1; opcode = LW; addr = 32'h0000_7000;
    tick();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk("fd_done", 32'(done), 32'd1);
    flush = 1'b1; mem_en = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    chk("fd_after", 32'(done), 32'd0);
    chk("fd_stall", 32'(stall), 32'd0);

    // Reset while waiting for data_ok
    mem_en = 1'b1; opcode = LW; addr = 32'h0000_6000;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; rst = 1'b1; mem_en = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rw_req", 32'(data_req), 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_rdata", rdata, 32'd0);
    chk("rw_done", 32'(done), 32'd0);
    chk("rw_addr", data_addr, 32'd0);
    tick();
    chk("rw_idle_req", 32'(data_req), 32'd0);

    // Randomized mix against the model
    for (int it = 0; it < 60; it++) begin
      logic [5:0]  op;
      logic [31:0] a;
      int n;
      if ($urandom_range(0, 9) < 8) op = mem_ops[$urandom_range(0, 7)];
      else op = other_ops[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      n = op_bytes(op);
      if (n == 0) run_noissue(op, a, 1'b0);
      else if ((int'(a[1:0]) % n) != 0) run_noissue(op, a, 1'b1);
      else run_txn(op, a, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
